to8bit_stream: RTL and testbench
================================

Name: to8bit_stream

Overview:
- Parametrised successor of the fixed 8/16/32-to-8 converter.
- Serialises words of 1, 2, 4 … RATIO lanes of OUT_W bits into a single OUT_W-bit stream.
- Uses valid/ready handshakes on both sides and a one-word holding buffer, so back-to-back words stream without bubbles.
- Sits between wide producers (16/32-bit datapaths) and the byte-serial link, replacing the free-running counter scheme with flow control.

Parameters:
- OUT_W, 8, width of one output lane in bits.
- RATIO, 4, maximum lanes per word; power of two, at least 2. Input width IN_W = OUT_W*RATIO (localparam).
- SW, 2, width of dataS.

Ports:
- clk  input  1  single clock, base frequency.
- rst  input  1  reset.
- enb  input  1  global enable; 0 freezes the block.
- dataIn  input  IN_W  input word; active lanes right-aligned in dataIn[L*OUT_W-1:0].
- dataS  input  SW  word size select, sampled with the word.
- inValid  input  1  producer has a word.
- inReady  output  1  block accepts a word this cycle.
- dataOut  output  OUT_W  current lane.
- outValid  output  1  dataOut valid.
- outReady  input  1  consumer takes dataOut this cycle.
- outLast  output  1  dataOut is the final lane of its word.

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Lane count L = 2^dataS if 2^dataS <= RATIO, else L = 1. With defaults: 00/11 -> 1 lane, 01 -> 2, 10 -> 4, matching the legacy encoding.
- Storage:
  - Holding buffer: bufWord, bufL, bufValid.
  - Shift stage: curWord, curL, cnt (log2(RATIO) bits), curValid.
- Accept: when inValid & inReady at a rising edge, dataIn and L are captured into the buffer and bufValid is set.
- load = bufValid & (~curValid | (outReady & outLast)).
- inReady = enb & (~bufValid | load). This is a combinational path from outReady to inReady and is permitted.
- On load: curWord <= bufWord, curL <= bufL, cnt <= 0, curValid <= 1. bufValid is cleared unless a new word is accepted on the same edge.
- Advance: outValid & outReady & ~outLast -> cnt <= cnt+1.
- Completion: outValid & outReady & outLast with no load -> curValid <= 0, cnt <= 0.
- dataOut = lane (curL-1-cnt) of curWord, so the most significant active lane is sent first. This is combinational from registers.
- outLast = curValid & (cnt == curL-1).
- outValid = enb & curValid.
- Latency: the word accepted at edge E0 presents its first lane after edge E1, i.e. 2 cycles if the shift stage is free.
- Throughput: one lane per cycle sustained, including L=1 (one word per cycle).
- Backpressure: while outValid & ~outReady, dataOut, outLast and cnt hold stable. No lane is lost or duplicated.
- enb=0: all registers hold; inReady and outValid are forced to 0. Streaming resumes at the same lane when enb returns to 1.
- Size changes between words are allowed; each word uses its own captured L. A dataS change while a word is shifting has no effect on that word.
- Reset (rst=0, asynchronous, any time):
  - bufValid, curValid, cnt, curWord, bufWord, curL, bufL all cleared.
  - Outputs go immediately to dataOut=0, outValid=0, outLast=0.
  - A partially sent word is discarded; inReady is 1 from the first edge after release (if enb=1).

Optional Feature:
- Macro: TO8BIT_LSB_FIRST_EN.
- Defined: lane order is reversed, dataOut = lane cnt of curWord (least significant lane first). outLast, timing and handshakes are unchanged.
- Undefined: MSB-lane-first order as above.

Test Plan:
- Single 32-bit word: dataS=10, dataIn=32'hA1B2C3D4, outReady=1 -> dataOut A1,B2,C3,D4 on 4 consecutive cycles, first lane 2 cycles after accept, outLast only with D4.
- Two back-to-back 16-bit words: dataS=01, words 16'h1234 then 16'h5678, outReady=1 -> 12,34,56,78 with no gap; second word accepted during the 12/34 shifting.
- 8-bit streaming: dataS=00 then 11, bytes 01..08 presented continuously -> one byte per cycle with outLast on every byte; inReady stays 1 after the first cycle.
- Backpressure: dataS=10, 32'hDEADBEEF, outReady pattern 1,0,0,1,0,1,1 -> DE,AD,BE,EF each delivered exactly once; dataOut stable during outReady=0.
- Reset mid-word: rst=0 asynchronously while AD is presented -> outValid=0 with no clock edge. After release, word 16'hCAFE with dataS=01 -> CA,FE.
- Freeze: enb=0 for 3 cycles after BE is presented -> outValid=0 and inReady=0 for those cycles; after enb=1 dataOut=BE, then EF.

Source files
------------

// File: rtl/to8bit_stream.sv
// Serialises 1..RATIO-lane words into an OUT_W-bit stream with valid/ready on both sides.
// Optional TO8BIT_LSB_FIRST_EN: send the least significant lane first instead of the most significant.
module to8bit_stream #(
   parameter int OUT_W = 8,
   parameter int RATIO = 4,
   parameter int SW    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enb,
   input  logic [OUT_W*RATIO-1:0] dataIn,
   input  logic [SW-1:0]          dataS,
   input  logic                   inValid,
   output logic                   inReady,
   output logic [OUT_W-1:0]       dataOut,
   output logic                   outValid,
   input  logic                   outReady,
   output logic                   outLast
);

   localparam int IN_W = OUT_W * RATIO;
   localparam int CW   = $clog2(RATIO);
   localparam int LW   = CW + 1;

   logic [IN_W-1:0] r_bufWord;
   logic [LW-1:0]   r_bufL;
   logic            r_bufValid;
   logic [IN_W-1:0] r_curWord;
   logic [LW-1:0]   r_curL;
   logic [CW-1:0]   r_cnt;
   logic            r_curValid;

   logic [LW-1:0]   w_inL;
   logic [CW-1:0]   w_lastIdx;
   logic [CW-1:0]   w_laneIdx;
   logic            w_load;
   logic            w_accept;
   logic            w_outFire;

   // Encodings asking for more lanes than RATIO fall back to a single lane.
   always_comb begin
      w_inL = LW'(1);
      if (int'(dataS) <= CW)
         w_inL = LW'(1) << dataS;
   end

   assign w_lastIdx = CW'(r_curL - LW'(1));
   assign outLast   = r_curValid & (r_cnt == w_lastIdx);
   assign outValid  = enb & r_curValid;

`ifdef TO8BIT_LSB_FIRST_EN
   assign w_laneIdx = r_cnt;
`else
   assign w_laneIdx = w_lastIdx - r_cnt;
`endif

   always_comb begin
      dataOut = '0;
      for (int i = 0; i < RATIO; i++)
         if (w_laneIdx == CW'(i))
            dataOut = r_curWord[i*OUT_W +: OUT_W];
   end

   // The buffer can refill on the same edge it hands its word to the shift stage.
   assign w_load    = r_bufValid & (~r_curValid | (outReady & outLast));
   assign inReady   = enb & (~r_bufValid | w_load);
   assign w_accept  = inValid & inReady;
   assign w_outFire = outValid & outReady;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bufWord  <= '0;
         r_bufL     <= '0;
         r_bufValid <= 1'b0;
      end else if (enb) begin
         if (w_accept) begin
            r_bufWord  <= dataIn;
            r_bufL     <= w_inL;
            r_bufValid <= 1'b1;
         end else if (w_load) begin
            r_bufValid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_curWord  <= '0;
         r_curL     <= '0;
         r_cnt      <= '0;
         r_curValid <= 1'b0;
      end else if (enb) begin
         if (w_load) begin
            r_curWord  <= r_bufWord;
            r_curL     <= r_bufL;
            r_cnt      <= '0;
            r_curValid <= 1'b1;
         end else if (w_outFire) begin
            if (outLast) begin
               r_curValid <= 1'b0;
               r_cnt      <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_to8bit_stream.sv
// Scoreboard bench for to8bit_stream: drivers queue expected lanes, a negedge monitor checks each handshake.
module tb_to8bit_stream;

   localparam int OUT_W = 8;
   localparam int RATIO = 4;
   localparam int SW    = 2;
   localparam int IN_W  = OUT_W * RATIO;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            enb = 1'b1;
   logic [IN_W-1:0] dataIn = '0;
   logic [SW-1:0]   dataS = '0;
   logic            inValid = 1'b0;
   logic            inReady;
   logic [OUT_W-1:0] dataOut;
   logic            outValid;
   logic            outReady = 1'b1;
   logic            outLast;

   always #5 clk = ~clk;

   to8bit_stream #(.OUT_W(OUT_W), .RATIO(RATIO), .SW(SW)) dut (
      .clk(clk), .rst(rst), .enb(enb), .dataIn(dataIn), .dataS(dataS),
      .inValid(inValid), .inReady(inReady), .dataOut(dataOut),
      .outValid(outValid), .outReady(outReady), .outLast(outLast)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       last;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop one expected lane per handshake; during backpressure the lane must hold.
   logic       hold_prev = 1'b0;
   logic [7:0] prev_d = '0;
   logic       prev_l = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst && outValid && outReady) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_lane: got %0h expected none", dataOut);
         end else begin
            e = q.pop_front();
            chk("lane_data", 32'(dataOut), 32'(e.d));
            chk("lane_last", 32'(outLast), 32'(e.last));
         end
      end
      if (rst && outValid && hold_prev) begin
         chk("hold_data", 32'(dataOut), 32'(prev_d));
         chk("hold_last", 32'(outLast), 32'(prev_l));
      end
      hold_prev = rst && outValid && !outReady;
      prev_d    = dataOut;
      prev_l    = outLast;
   end

   // Queue the expected lanes, then hold the word until a cycle with inReady=1 ends in an edge.
   task automatic send(input logic [31:0] w, input logic [1:0] s, output int stalls);
      int  L;
      int  idx;
      bit  acc;
      exp_t e;
      L = (s <= 2) ? (1 << s) : 1;
      for (int k = 0; k < L; k++) begin
`ifdef TO8BIT_LSB_FIRST_EN
         idx = k;
`else
         idx = L - 1 - k;
`endif
         e.d    = w[idx*8 +: 8];
         e.last = (k == L - 1);
         q.push_back(e);
      end
      dataIn  = w;
      dataS   = s;
      inValid = 1'b1;
      stalls  = 0;
      acc     = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = inReady;
         @(posedge clk);
         if (!acc) stalls++;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
      end
      #1 inValid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk);
         seen = outValid;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 40 && q.size() != 0; c++) begin
         @(negedge clk);
         #1;
      end
      chk(name, 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   int st;
   int st1;
   logic [7:0] pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // reset state
      #3;
      chk("rst_outValid", 32'(outValid), 32'd0);
      chk("rst_dataOut",  32'(dataOut),  32'd0);
      chk("rst_outLast",  32'(outLast),  32'd0);
      #10 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_reset", 32'(inReady), 32'd1);
      @(posedge clk);
      #1;

      // single 32-bit word, latency and contiguous lanes
      send(32'hA1B2C3D4, 2'b10, st);
      dataS = 2'b00;
      @(negedge clk);
      chk("t1_not_yet", 32'(outValid), 32'd0);
      @(negedge clk);
      chk("t1_first_valid", 32'(outValid), 32'd1);
      chk("t1_first_lane",  32'(dataOut),  32'hA1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t1_streak", 32'(outValid), 32'd1);
      end
      drain("t1_drain");

      // two back-to-back 16-bit words
      send(32'h0000_1234, 2'b01, st);
      send(32'h0000_5678, 2'b01, st1);
      chk("t2_second_stall", 32'(st1), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_no_gap", 32'(outValid), 32'd1);
      end
      drain("t2_drain");

      // byte streaming, dataS=11 clips to one lane, junk in upper lanes ignored
      for (int i = 1; i <= 8; i++) begin
         send({24'hEEEEEE, 8'(i)}, (i <= 4) ? 2'b00 : 2'b11, st);
         chk("t3_no_stall", 32'(st), 32'd0);
      end
      drain("t3_drain");

      // backpressure pattern
      outReady = 1'b0;
      send(32'hDEADBEEF, 2'b10, st);
      wait_valid("t4_valid");
      @(posedge clk);
      #1;
      for (int k = 0; k < 7; k++) begin
         outReady = pat[k][0];
         @(posedge clk);
         #1;
      end
      outReady = 1'b1;
      drain("t4_drain");

      // asynchronous reset mid-word
      outReady = 1'b0;
      send(32'hDEADBEEF, 2'b10, st);
      wait_valid("t5_valid");
      @(posedge clk);
      #1 outReady = 1'b1;
      @(posedge clk);
      #1 outReady = 1'b0;
      chk("t5_lane_AD", 32'(dataOut), 32'hAD);
      #1 rst = 1'b0;
      #1;
      chk("t5_async_outValid", 32'(outValid), 32'd0);
      chk("t5_async_dataOut",  32'(dataOut),  32'd0);
      chk("t5_async_outLast",  32'(outLast),  32'd0);
      q.delete();
      #10 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t5_ready_after_release", 32'(inReady), 32'd1);
      @(posedge clk);
      #1 outReady = 1'b1;
      send(32'h0000_CAFE, 2'b01, st);
      drain("t5_drain");

      // freeze with enb=0 while BE is presented
      send(32'hDEADBEEF, 2'b10, st);
      repeat (3) @(posedge clk);
      #1 enb = 1'b0;
      chk("t6_lane_BE", 32'(dataOut), 32'hBE);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_frz_outValid", 32'(outValid), 32'd0);
         chk("t6_frz_inReady",  32'(inReady),  32'd0);
         chk("t6_frz_dataOut",  32'(dataOut),  32'hBE);
         @(posedge clk);
         #1;
      end
      enb = 1'b1;
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
